mc_ctrl_fsm: RTL and testbench

- Multi-cycle MIPS main controller and ALU-control decoder: the driving side of the ALU interface.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Generates ALUC and the operand-mux selects, and consumes the ALU Zero flag to resolve branches.
- Also drives memory, IR, register-file and PC enables for the multi-cycle datapath.

---
 rtl/mc_ctrl_fsm.sv | 249 ++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
//   Multi-cycle MIPS main controller with integrated ALU-control decode.
//   Steps each instruction through FETCH/DECODE/execute/memory/writeback
//   states and drives the datapath enables and mux selects. Outputs are
//   Moore (decoded from the current state). The one exception is PCEn in
//   BRANCH, which follows the ALU Zero flag combinationally.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   Op, Funct       IR[31:26] / IR[5:0], held stable by the datapath
//   Zero            ALU zero flag, used to resolve beq/bne
//   ALUC            ALU operation select
//   ALUSrcA/B       ALU operand mux selects
//   ZeroExt         zero-extend the immediate (andi/ori)
//   IorD            memory address select, 0=PC 1=ALUOut
//   MemRead/Write   memory strobes (never both high)
//   IRWrite         instruction register load
//   RegDst          write register select, 0=rt 1=rd
//   MemtoReg        writeback data select, 0=ALUOut 1=MDR
//   RegWrite        register file write enable
//   PCSrc           PC source, 00=ALU 01=ALUOut 10=jump target
//   PCEn            PC load enable
//   Illegal         one-cycle pulse on an unsupported instruction
//   State           current state code, debug only
// ---------------------------------------------------------------------------
module mc_ctrl_fsm (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic [3:0] ALUC,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       ZeroExt,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic [1:0] PCSrc,
   output logic       PCEn,
   output logic       Illegal,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_RESET   = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_RTEX    = 4'd7,
      S_ALUWB   = 4'd8,
      S_BRANCH  = 4'd9,
      S_IMMEX   = 4'd10,
      S_IMMWB   = 4'd11,
      S_JUMP    = 4'd12,
      S_ILLEGAL = 4'd13
   } state_e;

   // opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type function codes
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALU control encodings
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   state_e state_q, state_d;

   // R-type funct decode; the flag tells DECODE whether to take RTEX.
   logic       fn_ok;
   logic [3:0] fn_aluc;

   always_comb begin
      fn_ok   = 1'b1;
      fn_aluc = ALU_ADD;
      case (Funct)
         FN_ADD:  fn_aluc = ALU_ADD;
         FN_SUB:  fn_aluc = ALU_SUB;
         FN_AND:  fn_aluc = ALU_AND;
         FN_OR:   fn_aluc = ALU_OR;
         FN_NOR:  fn_aluc = ALU_NOR;
         FN_SLT:  fn_aluc = ALU_SLT;
         default: fn_ok   = 1'b0;
      endcase
   end

   // Immediate-op decode, shared by IMMEX and IMMWB so the ALU result
   // stays consistent while it is written back.
   logic [3:0] imm_aluc;
   logic       imm_zext;

   always_comb begin
      imm_aluc = ALU_ADD;
      imm_zext = 1'b0;
      case (Op)
         OP_SLTI: imm_aluc = ALU_SLT;
         OP_ANDI: begin
            imm_aluc = ALU_AND;
            imm_zext = 1'b1;
         end
         OP_ORI: begin
            imm_aluc = ALU_OR;
            imm_zext = 1'b1;
         end
         default: imm_aluc = ALU_ADD;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_RESET;
      else        state_q <= state_d;
   end

   // next state
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_RESET:  state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (Op)
               OP_LW, OP_SW:                      state_d = S_MEMADR;
               OP_RTYPE:                          state_d = fn_ok ? S_RTEX : S_ILLEGAL;
               OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
               OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_IMMEX;
               OP_J:                              state_d = S_JUMP;
               default:                           state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR: state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_d = S_MEMWB;
         S_RTEX:   state_d = S_ALUWB;
         S_IMMEX:  state_d = S_IMMWB;
         // every terminal state, plus the unused codes 14/15, restarts fetch
         default:  state_d = S_FETCH;
      endcase
   end

   // outputs
   always_comb begin
      ALUC     = ALU_ADD;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      ZeroExt  = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      PCSrc    = 2'b00;
      PCEn     = 1'b0;
      Illegal  = 1'b0;
      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            IRWrite = 1'b1;
            ALUSrcB = 2'b01;
            PCEn    = 1'b1;
         end
         // PC+4+offset<<2 lands in ALUOut in case this turns out to be a branch
         S_DECODE: ALUSrcB = 2'b11;
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         S_RTEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b00;
            ALUC    = fn_aluc;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         // compare via subtract; Zero from this same cycle gates the PC load
         S_BRANCH: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b00;
            ALUC    = ALU_SUB;
            PCSrc   = 2'b01;
            PCEn    = (Op == OP_BNE) ? ~Zero : Zero;
         end
         S_IMMEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALUC    = imm_aluc;
            ZeroExt = imm_zext;
         end
         S_IMMWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b0;
            ALUC     = imm_aluc;
            ZeroExt  = imm_zext;
         end
         S_JUMP: begin
            PCSrc = 2'b10;
            PCEn  = 1'b1;
         end
         S_ILLEGAL: Illegal = 1'b1;
         default: ;
      endcase
   end

   assign State = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_fsm
//   Directed bench for mc_ctrl_fsm. All outputs are packed into one vector
//   and compared against hand-written per-state expectations at the falling
//   edge. Each test starts and ends with the FSM in FETCH.
// ---------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

   logic       clk;
   logic       rst_n;
   logic [5:0] Op;
   logic [5:0] Funct;
   logic       Zero;
   logic [3:0] ALUC;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       ZeroExt;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegDst;
   logic       MemtoReg;
   logic       RegWrite;
   logic [1:0] PCSrc;
   logic       PCEn;
   logic       Illegal;
   logic [3:0] State;

   int checks = 0;
   int errors = 0;

   mc_ctrl_fsm dut (
      .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero),
      .ALUC(ALUC), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ZeroExt(ZeroExt),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .PCSrc(PCSrc), .PCEn(PCEn), .Illegal(Illegal), .State(State)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // {ALUC, SrcA, SrcB, ZExt, IorD, MRd, MWr, IRW, RDst, M2R, RW, PCSrc, PCEn, Ill, State}
   logic [22:0] obs;
   assign obs = {ALUC, ALUSrcA, ALUSrcB, ZeroExt, IorD, MemRead, MemWrite, IRWrite,
                 RegDst, MemtoReg, RegWrite, PCSrc, PCEn, Illegal, State};

   function automatic logic [22:0] ev(
      input logic [3:0] st, input logic [3:0] aluc, input logic srca,
      input logic [1:0] srcb, input logic zext, input logic iord,
      input logic mrd, input logic mwr, input logic irw, input logic rdst,
      input logic m2r, input logic rw, input logic [1:0] pcsrc,
      input logic pcen, input logic ill);
      return {aluc, srca, srcb, zext, iord, mrd, mwr, irw, rdst, m2r, rw, pcsrc, pcen, ill, st};
   endfunction

   //                            st     aluc     A  B      Z  I  R  W  IR D  M  RW PCS    PE IL
   localparam logic [22:0] E_RESET  = ev(4'd0,  4'b0010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
   localparam logic [22:0] E_FETCH  = ev(4'd1,  4'b0010, 0, 2'b01, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 1, 0);
   localparam logic [22:0] E_DECODE = ev(4'd2,  4'b0010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
   localparam logic [22:0] E_MEMADR = ev(4'd3,  4'b0010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
   localparam logic [22:0] E_MEMRD  = ev(4'd4,  4'b0010, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
   localparam logic [22:0] E_MEMWB  = ev(4'd5,  4'b0010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0);
   localparam logic [22:0] E_MEMWR  = ev(4'd6,  4'b0010, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0);
   localparam logic [22:0] E_ALUWB  = ev(4'd8,  4'b0010, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 0, 0);
   localparam logic [22:0] E_BR_T   = ev(4'd9,  4'b0110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0);
   localparam logic [22:0] E_BR_N   = ev(4'd9,  4'b0110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0);
   localparam logic [22:0] E_JUMP   = ev(4'd12, 4'b0010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0);
   localparam logic [22:0] E_ILL    = ev(4'd13, 4'b0010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1);

   task automatic test_reset();
      rst_n = 1'b0; Op = 6'd0; Funct = 6'd0; Zero = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== E_RESET) begin
         errors++;
         $display("FAIL reset_hold got %h expected %h", obs, E_RESET);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== E_FETCH) begin
         errors++;
         $display("FAIL reset_release got %h expected %h", obs, E_FETCH);
      end
   endtask

   task automatic test_lw();
      logic [22:0] seq [5];
      seq[0] = E_DECODE; seq[1] = E_MEMADR; seq[2] = E_MEMRD; seq[3] = E_MEMWB; seq[4] = E_FETCH;
      Op = 6'b100011; Funct = 6'b010101;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== seq[i]) begin
            errors++;
            $display("FAIL lw_step%0d got %h expected %h", i, obs, seq[i]);
         end
      end
   endtask

   task automatic test_sw();
      logic [22:0] seq [4];
      seq[0] = E_DECODE; seq[1] = E_MEMADR; seq[2] = E_MEMWR; seq[3] = E_FETCH;
      Op = 6'b101011;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== seq[i]) begin
            errors++;
            $display("FAIL sw_step%0d got %h expected %h", i, obs, seq[i]);
         end
      end
   endtask

   task automatic test_rtype(input logic [5:0] fn, input logic [3:0] aluc);
      logic [22:0] seq [4];
      seq[0] = E_DECODE;
      seq[1] = ev(4'd7, aluc, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      seq[2] = E_ALUWB; seq[3] = E_FETCH;
      Op = 6'b000000; Funct = fn;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== seq[i]) begin
            errors++;
            $display("FAIL rtype_%b_step%0d got %h expected %h", fn, i, obs, seq[i]);
         end
      end
   endtask

   task automatic test_branch(input logic [5:0] op, input logic z, input logic [22:0] e_br);
      logic [22:0] seq [3];
      seq[0] = E_DECODE; seq[1] = e_br; seq[2] = E_FETCH;
      Op = op; Zero = z;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== seq[i]) begin
            errors++;
            $display("FAIL branch_%b_z%0b_step%0d got %h expected %h", op, z, i, obs, seq[i]);
         end
      end
   endtask

   // PCEn follows Zero inside the BRANCH cycle with no clock edge in between
   task automatic test_branch_comb();
      Op = 6'b000100; Zero = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (PCEn !== 1'b0 || State !== 4'd9) begin
         errors++;
         $display("FAIL beq_comb_z0 got pcen=%b state=%0d expected pcen=0 state=9", PCEn, State);
      end
      #1 Zero = 1'b1;
      #1;
      checks++;
      if (PCEn !== 1'b1 || State !== 4'd9) begin
         errors++;
         $display("FAIL beq_comb_z1 got pcen=%b state=%0d expected pcen=1 state=9", PCEn, State);
      end
      @(negedge clk);
      Zero = 1'b0;
      checks++;
      if (obs !== E_FETCH) begin
         errors++;
         $display("FAIL beq_comb_ret got %h expected %h", obs, E_FETCH);
      end
   endtask

   task automatic test_imm(input logic [5:0] op, input logic [3:0] aluc, input logic zx);
      logic [22:0] seq [4];
      seq[0] = E_DECODE;
      seq[1] = ev(4'd10, aluc, 1, 2'b10, zx, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      seq[2] = ev(4'd11, aluc, 0, 2'b00, zx, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0);
      seq[3] = E_FETCH;
      Op = op;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== seq[i]) begin
            errors++;
            $display("FAIL imm_%b_step%0d got %h expected %h", op, i, obs, seq[i]);
         end
      end
   endtask

   task automatic test_jump();
      logic [22:0] seq [3];
      seq[0] = E_DECODE; seq[1] = E_JUMP; seq[2] = E_FETCH;
      Op = 6'b000010;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== seq[i]) begin
            errors++;
            $display("FAIL jump_step%0d got %h expected %h", i, obs, seq[i]);
         end
      end
   endtask

   task automatic test_illegal(input logic [5:0] op, input logic [5:0] fn);
      logic [22:0] seq [3];
      seq[0] = E_DECODE; seq[1] = E_ILL; seq[2] = E_FETCH;
      Op = op; Funct = fn;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== seq[i]) begin
            errors++;
            $display("FAIL illegal_%b_%b_step%0d got %h expected %h", op, fn, i, obs, seq[i]);
         end
      end
   endtask

   // abandon a load in MEMRD; reset must clear outputs without a clock edge
   task automatic test_reset_mid();
      Op = 6'b100011;
      repeat (3) @(negedge clk);
      checks++;
      if (obs !== E_MEMRD) begin
         errors++;
         $display("FAIL rstmid_memrd got %h expected %h", obs, E_MEMRD);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== E_RESET) begin
         errors++;
         $display("FAIL rstmid_async got %h expected %h", obs, E_RESET);
      end
      @(negedge clk);
      checks++;
      if (obs !== E_RESET) begin
         errors++;
         $display("FAIL rstmid_hold got %h expected %h", obs, E_RESET);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== E_FETCH) begin
         errors++;
         $display("FAIL rstmid_release got %h expected %h", obs, E_FETCH);
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw();
      test_rtype(6'b100111, 4'b1100);
      test_rtype(6'b101010, 4'b0111);
      test_rtype(6'b100010, 4'b0110);
      test_rtype(6'b100000, 4'b0010);
      test_rtype(6'b100100, 4'b0000);
      test_rtype(6'b100101, 4'b0001);
      test_branch(6'b000100, 1'b1, E_BR_T);
      test_branch(6'b000100, 1'b0, E_BR_N);
      test_branch(6'b000101, 1'b0, E_BR_T);
      test_branch(6'b000101, 1'b1, E_BR_N);
      test_branch_comb();
      test_imm(6'b001101, 4'b0001, 1'b1);
      test_imm(6'b001000, 4'b0010, 1'b0);
      test_imm(6'b001010, 4'b0111, 1'b0);
      test_imm(6'b001100, 4'b0000, 1'b1);
      test_jump();
      test_illegal(6'b111111, 6'b100000);
      test_illegal(6'b000000, 6'b000000);
      test_reset_mid();
      test_lw();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
